hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 53 +++++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   The bundle of signals between the pipeline control and the hazard
//   scoreboard.
//   master : the pipeline side. It drives the D/E-stage instruction
//            information and the flush request, and receives the
//            forwarding selects, stall, mdu_busy and the stall counter.
//   slave  : the scoreboard side.
//   Signals
//     D_ReadA    NRD*AW    D-stage read addresses, port i at [i*AW +: AW]
//     D_Tuse     NRD*TW    cycles until port i needs its operand
//     D_WriteA   AW        destination register of the D instruction
//     D_RegWrite 1         D instruction writes a register
//     D_Tnew     TW        cycles after E until the result exists
//     D_MDUClass 1         D instruction touches the MDU
//     E_MDUStart 1         MDU operation starts in E this cycle
//     E_MDUDiv   1         the starting operation is a divide
//     IntExcReq  1         interrupt/exception flush
//     D_FwdSel   NRD*SELW  forward source per port (0 = register file)
//     stall      1         freeze F/D and insert a bubble into E
//     mdu_busy   1         MDU latency counter nonzero
//     stall_cnt  32        saturating count of stalled cycles
interface hazard_scoreboard_if #(
    parameter int NRD  = 2,
    parameter int AW   = 5,
    parameter int TW   = 2,
    parameter int SELW = 2
);
    logic [NRD*AW-1:0]   D_ReadA;
    logic [NRD*TW-1:0]   D_Tuse;
    logic [AW-1:0]       D_WriteA;
    logic                D_RegWrite;
    logic [TW-1:0]       D_Tnew;
    logic                D_MDUClass;
    logic                E_MDUStart;
    logic                E_MDUDiv;
    logic                IntExcReq;
    logic [NRD*SELW-1:0] D_FwdSel;
    logic                stall;
    logic                mdu_busy;
    logic [31:0]         stall_cnt;

    modport master (
        output D_ReadA, D_Tuse, D_WriteA, D_RegWrite, D_Tnew,
        output D_MDUClass, E_MDUStart, E_MDUDiv, IntExcReq,
        input  D_FwdSel, stall, mdu_busy, stall_cnt
    );

    modport slave (
        input  D_ReadA, D_Tuse, D_WriteA, D_RegWrite, D_Tnew,
        input  D_MDUClass, E_MDUStart, E_MDUDiv, IntExcReq,
        output D_FwdSel, stall, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tnew/Tuse hazard scoreboard for the D stage of an in-order pipeline.
//   It tracks the destination and remaining Tnew of the instructions in
//   the NSTAGE stages after D (entry 0 = E). For every D read port it
//   picks the youngest in-flight writer of that register. If that writer's
//   result is ready it forwards it, and if the result arrives too late for
//   the port's Tuse it stalls. A latency counter models the multi-cycle
//   MDU, so that MDU-class instructions wait while it is busy.
//   Ports
//     clk    sole clock, rising edge
//     reset  synchronous active-high reset
//     bus    hazard_scoreboard_if.slave (all D/E inputs and outputs)
//   NSTAGE must be less than 2**SELW so that every entry has a select code.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int NRD      = 2,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int SELW     = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);
    localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [NSTAGE-1:0]   valid_reg;
    logic [AW-1:0]       addr_reg [NSTAGE];
    logic [TW-1:0]       tnew_reg [NSTAGE];
    logic [CW-1:0]       mdu_cnt_reg;
    logic [31:0]         stall_cnt_reg;

    logic [NRD-1:0]      port_hazard;
    logic [NRD*SELW-1:0] fwd_sel;
    logic                mdu_busy;
    logic                stall;

    // Per read port: find the youngest matching entry. Scanning from the
    // oldest entry to the youngest and overwriting leaves the lowest index.
    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0]   rd_addr;
            logic [TW-1:0]   tuse;
            logic            hit;
            logic [TW-1:0]   hit_tnew;
            logic [SELW-1:0] hit_sel;

            assign rd_addr = bus.D_ReadA[gi*AW +: AW];
            assign tuse    = bus.D_Tuse[gi*TW +: TW];

            always_comb begin
                hit      = 1'b0;
                hit_tnew = '0;
                hit_sel  = '0;
                for (int k = NSTAGE - 1; k >= 0; k--) begin
                    if (valid_reg[k] && (addr_reg[k] == rd_addr) && (rd_addr != '0)) begin
                        hit      = 1'b1;
                        hit_tnew = tnew_reg[k];
                        hit_sel  = SELW'(k + 1);
                    end
                end
            end

            assign fwd_sel[gi*SELW +: SELW] = (hit && (hit_tnew == '0)) ? hit_sel : '0;
            assign port_hazard[gi]          = hit && (hit_tnew > tuse);
        end
    endgenerate

    assign mdu_busy = (mdu_cnt_reg != '0);

    // A flush wins over every stall source: the stalled instruction is
    // being thrown away.
    assign stall = ((|port_hazard) ||
                    (bus.D_MDUClass && (mdu_busy || bus.E_MDUStart))) &&
                   !bus.IntExcReq;

    // Scoreboard shift. A stall only replaces the incoming entry with a
    // bubble; older entries keep moving because E/M/W keep moving.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                addr_reg[k] <= '0;
                tnew_reg[k] <= '0;
            end
        end else if (bus.IntExcReq) begin
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= !stall && bus.D_RegWrite && (bus.D_WriteA != '0);
            addr_reg[0]  <= bus.D_WriteA;
            tnew_reg[0]  <= bus.D_Tnew;
            for (int k = 1; k < NSTAGE; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                addr_reg[k]  <= addr_reg[k-1];
                tnew_reg[k]  <= (tnew_reg[k-1] != '0) ? tnew_reg[k-1] - TW'(1) : '0;
            end
        end
    end

    // MDU latency counter. A new start reloads even while it is busy, and a
    // flush does not touch it because the MDU finishes the operation anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_reg <= '0;
        end else if (bus.E_MDUStart) begin
            mdu_cnt_reg <= bus.E_MDUDiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (mdu_cnt_reg != '0) begin
            mdu_cnt_reg <= mdu_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign bus.D_FwdSel  = fwd_sel;
    assign bus.stall     = stall;
    assign bus.mdu_busy  = mdu_busy;
    assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed scenarios followed by random traffic. Every cycle the
//   hazard_scoreboard outputs are compared with a reference model. The model
//   keeps a list of issued writers, each with the cycle it left D. From
//   that it works out the stage and the remaining Tnew of each writer, and
//   it treats the MDU as a "busy until cycle" value.
module tb_hazard_scoreboard;
    localparam int NSTAGE   = 3;
    localparam int NRD      = 2;
    localparam int AW       = 5;
    localparam int TW       = 2;
    localparam int SELW     = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NRD(NRD), .AW(AW), .TW(TW), .SELW(SELW)) bus ();

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .NRD(NRD), .AW(AW), .TW(TW), .SELW(SELW),
        .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            tnew_e;
        int            born;
    } inst_t;

    inst_t       flight[$];
    int          cyc = 0;
    int          busy_end = -1;
    logic [31:0] m_cnt = '0;
    int          passed = 0;
    int          total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // A writer that left D in cycle 'born' sits in scoreboard stage
    // cyc-born-1. Its remaining Tnew is its Tnew at E minus that many
    // cycles, and never goes below zero.
    function automatic void expect_port(input logic [AW-1:0] ra, input int tuse,
                                        output int fsel, output bit haz);
        int best = NSTAGE;
        int rem  = 0;
        fsel = 0;
        haz  = 1'b0;
        if (ra == '0) return;
        foreach (flight[j]) begin
            int idx = cyc - flight[j].born - 1;
            if (idx >= 0 && idx < NSTAGE && flight[j].addr == ra && idx < best) begin
                best = idx;
                rem  = flight[j].tnew_e - idx;
                if (rem < 0) rem = 0;
            end
        end
        if (best < NSTAGE) begin
            fsel = (rem == 0) ? best + 1 : 0;
            haz  = (rem > tuse);
        end
    endfunction

    // Checks the current cycle against the model, then advances one clock.
    task automatic step();
        int fs[NRD];
        bit hz[NRD];
        bit any_haz;
        bit busy;
        bit es;
        #1;
        any_haz = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            expect_port(bus.D_ReadA[i*AW +: AW], int'(bus.D_Tuse[i*TW +: TW]), fs[i], hz[i]);
            any_haz = any_haz | hz[i];
        end
        busy = (cyc <= busy_end);
        es   = (any_haz || (bus.D_MDUClass && (busy || bus.E_MDUStart))) && !bus.IntExcReq;
        for (int i = 0; i < NRD; i++)
            chk($sformatf("fwdsel%0d", i), 32'(bus.D_FwdSel[i*SELW +: SELW]), 32'(fs[i]));
        chk("stall", 32'(bus.stall), 32'(es));
        chk("mdu_busy", 32'(bus.mdu_busy), 32'(busy));
        chk("stall_cnt", bus.stall_cnt, m_cnt);

        if (reset) begin
            flight.delete();
            busy_end = -1;
            m_cnt    = '0;
        end else begin
            if (bus.IntExcReq)
                flight.delete();
            else if (!es && bus.D_RegWrite && bus.D_WriteA != '0)
                flight.push_back('{bus.D_WriteA, int'(bus.D_Tnew), cyc});
            if (bus.E_MDUStart)
                busy_end = cyc + (bus.E_MDUDiv ? DIV_CYC : MULT_CYC);
            if (es && m_cnt != 32'hFFFF_FFFF)
                m_cnt = m_cnt + 32'd1;
        end
        while (flight.size() > 0 && (cyc - flight[0].born) >= NSTAGE)
            void'(flight.pop_front());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.D_ReadA    = '0;
        bus.D_Tuse     = '0;
        bus.D_WriteA   = '0;
        bus.D_RegWrite = 1'b0;
        bus.D_Tnew     = '0;
        bus.D_MDUClass = 1'b0;
        bus.E_MDUStart = 1'b0;
        bus.E_MDUDiv   = 1'b0;
        bus.IntExcReq  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();
        step();
        #1;
        chk("rst_fwd", 32'(bus.D_FwdSel), 32'd0);
        chk("rst_busy", 32'(bus.mdu_busy), 32'd0);

        // Load to $2 with Tnew=2, consumer with Tuse=0: two stalls, then forward from W.
        bus.D_WriteA = 5'd2; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd2;
        step();
        idle();
        bus.D_ReadA[AW-1:0] = 5'd2;
        step();
        step();
        #1;
        chk("load_fwd", 32'(bus.D_FwdSel[SELW-1:0]), 32'd3);
        chk("load_stall", 32'(bus.stall), 32'd0);
        chk("load_cnt", bus.stall_cnt, 32'd2);
        step();

        // ALU write $3 with Tnew=1: Tuse=0 stalls once, then forwards from M.
        do_reset();
        bus.D_WriteA = 5'd3; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd1;
        step();
        idle();
        bus.D_ReadA[2*AW-1:AW] = 5'd3;
        step();
        #1;
        chk("alu_fwd", 32'(bus.D_FwdSel[2*SELW-1:SELW]), 32'd2);
        step();
        // Same producer, Tuse=1: no stall, no forward in the first cycle.
        do_reset();
        bus.D_WriteA = 5'd3; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd1;
        step();
        idle();
        bus.D_ReadA[2*AW-1:AW] = 5'd3; bus.D_Tuse[2*TW-1:TW] = 2'd1;
        #1;
        chk("alu_tuse1_stall", 32'(bus.stall), 32'd0);
        chk("alu_tuse1_fwd", 32'(bus.D_FwdSel), 32'd0);
        step();
        step();

        // A write to $0 never creates a dependency.
        do_reset();
        bus.D_WriteA = 5'd0; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd3;
        step();
        repeat (3) step();

        // A divide with an MDU-class instruction waiting in D: 11 stall cycles.
        do_reset();
        bus.D_MDUClass = 1'b1; bus.E_MDUStart = 1'b1; bus.E_MDUDiv = 1'b1;
        step();
        bus.E_MDUStart = 1'b0;
        repeat (10) step();
        #1;
        chk("div_stall_end", 32'(bus.stall), 32'd0);
        chk("div_cnt", bus.stall_cnt, 32'd11);
        step();

        // A flush drops an active load-use stall and empties the scoreboard.
        do_reset();
        bus.D_WriteA = 5'd2; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd2;
        step();
        idle();
        bus.D_ReadA[AW-1:0] = 5'd2;
        #1;
        chk("flush_pre", 32'(bus.stall), 32'd1);
        bus.IntExcReq = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall), 32'd0);
        step();
        bus.IntExcReq = 1'b0;
        #1;
        chk("flush_fwd", 32'(bus.D_FwdSel), 32'd0);
        chk("flush_post", 32'(bus.stall), 32'd0);
        step();

        // Two writers of $4: the younger one in E wins. Then reset mid-MDU.
        do_reset();
        bus.D_WriteA = 5'd4; bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd0;
        bus.E_MDUStart = 1'b1;
        step();
        bus.E_MDUStart = 1'b0;
        step();
        idle();
        bus.D_ReadA[AW-1:0] = 5'd4;
        bus.D_MDUClass = 1'b1;
        #1;
        chk("dual_fwd", 32'(bus.D_FwdSel[SELW-1:0]), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        chk("rst2_fwd", 32'(bus.D_FwdSel), 32'd0);
        chk("rst2_busy", 32'(bus.mdu_busy), 32'd0);
        chk("rst2_cnt", bus.stall_cnt, 32'd0);
        step();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NRD; i++) begin
                bus.D_ReadA[i*AW +: AW] = AW'($urandom_range(0, 7));
                bus.D_Tuse[i*TW +: TW]  = TW'($urandom_range(0, 3));
            end
            bus.D_WriteA   = AW'($urandom_range(0, 7));
            bus.D_RegWrite = ($urandom_range(0, 2) != 0);
            bus.D_Tnew     = TW'($urandom_range(0, 3));
            bus.D_MDUClass = ($urandom_range(0, 3) == 0);
            bus.E_MDUStart = ($urandom_range(0, 11) == 0);
            bus.E_MDUDiv   = $urandom_range(0, 1) == 1;
            bus.IntExcReq  = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
